// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix display sequencer: mode and blink-phase
// encodings plus the default matrix geometry.
package matrix_pkg;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'b00,
        MODE_FORCE  = 2'b01,
        MODE_FREEZE = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    typedef enum logic {
        PHASE_VISIBLE = 1'b0,
        PHASE_BLANK   = 1'b1
    } blink_phase_e;

    localparam int DEFAULT_ROWS = 7;
    localparam int DEFAULT_COLS = 5;

endpackage

// File: rtl/matrix_tick_divider.sv
// Terminal-count tick counter: counts accepted ticks and flags the tick that
// reaches TERMINAL, wrapping back to zero. Clear has priority and suppresses
// the hit in the same cycle.
module matrix_tick_divider #(
    parameter int TERMINAL = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic tick,
    output logic hit
);

    localparam int CNT_W = $clog2(TERMINAL + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count and terminal-count detection.
    always_comb begin
        cnt_d = cnt_q;
        hit   = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_W'(TERMINAL - 1)) begin
                cnt_d = '0;
                hit   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/matrix_display_sequencer.sv
// Rotates a ROWSxCOLS LED matrix through NUM_PAGES images with a tick-based
// dwell timer, force/freeze/off modes and an alarm blink overlay. All outputs
// are registered and mutually aligned, one cycle behind their inputs.
module matrix_display_sequencer
    import matrix_pkg::*;
#(
    parameter int ROWS        = DEFAULT_ROWS,
    parameter int COLS        = DEFAULT_COLS,
    parameter int NUM_PAGES   = 2,
    parameter int DWELL_TICKS = 4,
    parameter int BLINK_TICKS = 1,
    localparam int FRAME_W    = ROWS * COLS,
    localparam int PAGE_W     = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           tick,
    input  logic [NUM_PAGES*FRAME_W-1:0]   page_data,
    input  logic [1:0]                     mode,
    input  logic [PAGE_W-1:0]              force_page,
    input  logic                           alarm,
    output logic [FRAME_W-1:0]             columns,
    output logic [PAGE_W-1:0]              active_page,
    output logic                           page_advance,
    output logic                           blank
);

    mode_e                mode_s;

    logic                 was_auto_q;
    logic                 was_auto_d;
    logic                 dwell_clear;
    logic                 dwell_tick;
    logic                 dwell_hit;
    logic                 blink_clear;
    logic                 blink_tick;
    logic                 blink_hit;

    blink_phase_e         blink_phase_q;
    blink_phase_e         blink_phase_d;
    logic [PAGE_W-1:0]    active_page_q;
    logic [PAGE_W-1:0]    active_page_d;
    logic                 page_advance_q;
    logic                 page_advance_d;
    logic                 blank_q;
    logic                 blank_d;
    logic [FRAME_W-1:0]   columns_q;
    logic [FRAME_W-1:0]   columns_d;
    logic [FRAME_W-1:0]   page_frame;

    logic [FRAME_W-1:0]   page_frames [NUM_PAGES];

    // Unpack the flat page bus into one frame per page.
    generate
        for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_page_unpack
            assign page_frames[gi] = page_data[gi*FRAME_W +: FRAME_W];
        end
    endgenerate

    // Timer control: the dwell timer runs only in AUTO, holds in FREEZE and is
    // zeroed otherwise; the first AUTO cycle after another mode restarts the
    // dwell so a full period elapses before the next advance. The blink timer
    // runs only while alarm is raised and the display is not OFF.
    always_comb begin
        mode_s      = mode_e'(mode);
        was_auto_d  = (mode_s == MODE_AUTO);
        dwell_tick  = tick && (mode_s == MODE_AUTO);
        dwell_clear = (mode_s == MODE_FORCE) || (mode_s == MODE_OFF) ||
                      ((mode_s == MODE_AUTO) && !was_auto_q);
        blink_clear = !alarm || (mode_s == MODE_OFF);
        blink_tick  = tick && alarm && (mode_s != MODE_OFF);
    end

    matrix_tick_divider #(
        .TERMINAL (DWELL_TICKS)
    ) u_dwell_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (dwell_clear),
        .tick    (dwell_tick),
        .hit     (dwell_hit)
    );

    matrix_tick_divider #(
        .TERMINAL (BLINK_TICKS)
    ) u_blink_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (blink_clear),
        .tick    (blink_tick),
        .hit     (blink_hit)
    );

    // Page selection, advance pulse, blink phase, blanking and frame mux.
    always_comb begin
        active_page_d  = active_page_q;
        page_advance_d = 1'b0;
        blink_phase_d  = blink_phase_q;
        page_frame     = '0;

        case (mode_s)
            MODE_AUTO: begin
                if (dwell_hit && (NUM_PAGES > 1)) begin
                    page_advance_d = 1'b1;
                    if (active_page_q == PAGE_W'(NUM_PAGES - 1)) begin
                        active_page_d = '0;
                    end else begin
                        active_page_d = active_page_q + PAGE_W'(1);
                    end
                end
            end
            MODE_FORCE: begin
                // Out-of-range requests fall back to the first page.
                if ({1'b0, force_page} >= (PAGE_W + 1)'(NUM_PAGES)) begin
                    active_page_d = '0;
                end else begin
                    active_page_d = force_page;
                end
            end
            default: begin
                // FREEZE and OFF keep the current page.
            end
        endcase

        if (blink_clear) begin
            blink_phase_d = PHASE_VISIBLE;
        end else if (blink_hit) begin
            blink_phase_d = (blink_phase_q == PHASE_VISIBLE) ? PHASE_BLANK : PHASE_VISIBLE;
        end

        blank_d = (mode_s == MODE_OFF) || (blink_phase_d == PHASE_BLANK);

        for (int p = 0; p < NUM_PAGES; p++) begin
            if (active_page_d == PAGE_W'(p)) begin
                page_frame = page_frames[p];
            end
        end

        columns_d = blank_d ? '0 : page_frame;
    end

    // State and output registers; reset leaves the display dark on page 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            was_auto_q     <= 1'b1;
            blink_phase_q  <= PHASE_VISIBLE;
            active_page_q  <= '0;
            page_advance_q <= 1'b0;
            blank_q        <= 1'b1;
            columns_q      <= '0;
        end else begin
            was_auto_q     <= was_auto_d;
            blink_phase_q  <= blink_phase_d;
            active_page_q  <= active_page_d;
            page_advance_q <= page_advance_d;
            blank_q        <= blank_d;
            columns_q      <= columns_d;
        end
    end

    assign columns      = columns_q;
    assign active_page  = active_page_q;
    assign page_advance = page_advance_q;
    assign blank        = blank_q;

endmodule

// File: tb/tb_matrix_display_sequencer.sv
// Directed bench for matrix_display_sequencer (3 pages, dwell 4, blink 2).
// Expected outputs come from a behavioural model, queued when stimulus is
// applied and compared after the following clock edge.
module tb_matrix_display_sequencer;
    import matrix_pkg::*;

    localparam int ROWS    = 7;
    localparam int COLS    = 5;
    localparam int NP      = 3;
    localparam int DW      = 4;
    localparam int BT      = 2;
    localparam int FRAME_W = ROWS * COLS;
    localparam int PAGE_W  = 2;

    typedef struct {
        logic [FRAME_W-1:0] cols;
        logic [PAGE_W-1:0]  page;
        logic               adv;
        logic               blank;
    } exp_t;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b1;
    logic                   tick = 1'b0;
    logic                   alarm = 1'b0;
    logic [1:0]             mode = MODE_AUTO;
    logic [PAGE_W-1:0]      force_page = '0;
    logic [NP*FRAME_W-1:0]  page_data = '0;
    logic [FRAME_W-1:0]     columns;
    logic [PAGE_W-1:0]      active_page;
    logic                   page_advance;
    logic                   blank;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state.
    int m_page;
    int m_dwell;
    int m_bcnt;
    int m_phase;
    int m_was_auto;

    exp_t sbq[$];

    matrix_display_sequencer #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .NUM_PAGES   (NP),
        .DWELL_TICKS (DW),
        .BLINK_TICKS (BT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .tick         (tick),
        .page_data    (page_data),
        .mode         (mode),
        .force_page   (force_page),
        .alarm        (alarm),
        .columns      (columns),
        .active_page  (active_page),
        .page_advance (page_advance),
        .blank        (blank)
    );

    always #5 clock = ~clock;

    function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0] v);
        logic [FRAME_W-1:0] f;
        for (int i = 0; i < FRAME_W; i++) f[i] = v[i % 4];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_page     = 0;
        m_dwell    = 0;
        m_bcnt     = 0;
        m_phase    = 0;
        m_was_auto = 1;
        sbq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cols"},  64'(columns), 64'(0));
        chk({tag, "_blank"}, 64'(blank), 64'(1));
        chk({tag, "_page"},  64'(active_page), 64'(0));
        chk({tag, "_adv"},   64'(page_advance), 64'(0));
    endtask

    // One clock of stimulus: update the model from the current inputs, queue
    // the expected outputs, then compare after the edge.
    task automatic step(input logic t);
        exp_t e;
        exp_t got;
        int   adv;
        tick = t;
        adv  = 0;
        case (mode)
            MODE_AUTO: begin
                if (m_was_auto == 0) begin
                    m_dwell = 0;
                end else if (t) begin
                    if (m_dwell == DW - 1) begin
                        m_dwell = 0;
                        m_page  = (m_page == NP - 1) ? 0 : m_page + 1;
                        adv     = 1;
                    end else begin
                        m_dwell++;
                    end
                end
            end
            MODE_FORCE: begin
                m_page  = (int'(force_page) < NP) ? int'(force_page) : 0;
                m_dwell = 0;
            end
            MODE_FREEZE: begin
            end
            default: m_dwell = 0;
        endcase
        m_was_auto = (mode == MODE_AUTO) ? 1 : 0;
        if (!alarm || mode == MODE_OFF) begin
            m_bcnt  = 0;
            m_phase = 0;
        end else if (t) begin
            if (m_bcnt == BT - 1) begin
                m_bcnt  = 0;
                m_phase = 1 - m_phase;
            end else begin
                m_bcnt++;
            end
        end
        e.blank = (mode == MODE_OFF) || (m_phase == 1);
        e.cols  = e.blank ? '0 : page_data[m_page*FRAME_W +: FRAME_W];
        e.page  = PAGE_W'(m_page);
        e.adv   = adv[0];
        sbq.push_back(e);

        @(posedge clock);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 64'(1), 64'(0));
        end else begin
            got = sbq.pop_front();
            chk("cols",  64'(columns), 64'(got.cols));
            chk("page",  64'(active_page), 64'(got.page));
            chk("adv",   64'(page_advance), 64'(got.adv));
            chk("blank", 64'(blank), 64'(got.blank));
        end
        $display("[%0t] mode=%0d tick=%0b alarm=%0b force=%0d -> page=%0d adv=%0b blank=%0b cols=%h",
                 $time, mode, t, alarm, force_page, active_page, page_advance, blank, columns);
    endtask

    initial begin
        for (int p = 0; p < NP; p++) page_data[p*FRAME_W +: FRAME_W] = make_frame(4'(p + 1));
        model_reset();

        // Reset held with tick toggling.
        #3 reset_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1 tick = ~tick;
            check_reset_outputs("rst_hold");
        end
        tick    = 1'b0;
        reset_n = 1'b1;
        model_reset();
        step(0);                                   // page 0 after one edge

        // AUTO rotation across all pages, with wrap and idle cycles.
        for (int i = 0; i < 6; i++) step(1);
        step(0);
        step(0);
        for (int i = 0; i < 8; i++) step(1);       // dwell now mid-period

        // FORCE, including an out-of-range page, then back to AUTO.
        mode = MODE_FORCE; force_page = 2'd1;
        step(1);
        step(0);
        force_page = 2'd3;
        step(1);
        force_page = 2'd2;
        step(0);
        mode = MODE_AUTO;
        step(0);                                   // AUTO entry restarts dwell
        for (int i = 0; i < 6; i++) step(1);

        // FREEZE mid-dwell ignores ticks; OFF blanks and holds the page.
        mode = MODE_FREEZE;
        step(1);                                   // tick and mode change together
        for (int i = 0; i < 10; i++) step(1);
        mode = MODE_OFF;
        for (int i = 0; i < 3; i++) step(1);
        mode = MODE_AUTO;
        for (int i = 0; i < 5; i++) step(1);

        // Alarm blink overlay while rotation continues.
        alarm = 1'b1;
        for (int i = 0; i < 11; i++) step(1);
        for (int k = 0; k < 8 && m_phase == 0; k++) step(1);
        chk("blink_reached", 64'(blank), 64'(1));
        alarm = 1'b0;
        step(0);                                   // visible again next cycle
        alarm = 1'b1; mode = MODE_FORCE; force_page = 2'd0;
        for (int i = 0; i < 5; i++) step(1);
        alarm = 1'b0;

        // Data latency: change the active page's image.
        force_page = 2'd1;
        step(0);
        page_data[1*FRAME_W +: FRAME_W] = make_frame(4'h5);
        step(0);
        page_data[1*FRAME_W +: FRAME_W] = make_frame(4'ha);
        step(1);

        // Asynchronous reset mid-dwell between edges.
        mode = MODE_AUTO;
        step(0);
        step(1);
        #3 reset_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(posedge clock);
        #1 check_reset_outputs("rst_mid_hold");
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) step(1);
        tick = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
